burst_rr_arbiter3: RTL
======================

BURST_RR_ARBITER3 -- requirements
Module: burst_rr_arbiter3

Interface
REQ-001 SHALL have parameter: DATA_W, 32, payload width in bits per beat.
REQ-002 SHALL have parameter: STALL_W, 16, stall counter width (used only when ARB_STALL_CNT_EN is defined).
REQ-003 SHALL have port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  3  per-requester beat valid.
REQ-006 SHALL have port: in_ready  output  3  per-requester beat accepted.
REQ-007 SHALL have port: in_data  input  3*DATA_W  requester i payload at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port: in_last  input  3  per-requester final beat of a burst.
REQ-009 SHALL have port: out_valid  output  1  muxed beat valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accept.
REQ-011 SHALL have port: out_data  output  DATA_W  payload of the granted requester.
REQ-012 SHALL have port: out_last  output  1  in_last of the granted requester.
REQ-013 SHALL have port: out_sel  output  3  one-hot grant, qualified by out_valid; all zeros when out_valid=0.
REQ-014 SHALL have port: out_stall_cnt  output  STALL_W  saturating stall count.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (free arbitration) and LOCKED (burst in progress).
REQ-016 SHALL, in IDLE, grant the first valid requester scanning from ptr upward, modulo 3.
REQ-017 SHALL, in LOCKED, grant lock_idx unconditionally and ignore the other requesters.
REQ-018 SHALL drive out_valid = in_valid[grant] and out_sel = onehot(grant) & {3{out_valid}}, combinationally with zero latency.
REQ-019 SHALL drive in_ready[i] = out_ready & out_sel[i]; at most one bit of in_ready SHALL be high in any cycle.
REQ-020 SHALL define fire as out_valid & out_ready.
REQ-021 SHALL, on fire & !out_last in IDLE, move to LOCKED and set lock_idx = grant.
REQ-022 SHALL, on fire & out_last in either state, move to or stay in IDLE and set ptr = (grant+1) mod 3; a single-beat burst never enters LOCKED.
REQ-023 SHALL hold ptr and state when fire=0; a LOCKED requester dropping in_valid mid-burst keeps the lock, with out_valid=0.
REQ-024 SHALL keep grant stable while out_valid & !out_ready, even if a higher-priority requester becomes valid.

Reset
REQ-025 SHALL, while reset=1 at a clock edge, set state=IDLE, ptr=0, lock_idx=0, and stall count=0; the reset is honoured mid-burst, abandoning the lock.
REQ-026 SHALL generate outputs combinationally during reset from the reset state; downstream qualifies them with reset.

Configuration
REQ-027 SHALL, with ARB_STALL_CNT_EN defined, increment the stall count on every cycle with out_valid & !out_ready, saturate it at all-ones, and clear it only by reset.
REQ-028 SHALL, without ARB_STALL_CNT_EN, tie out_stall_cnt to 0 and synthesize no counter flops.

Structure
REQ-029 SHALL place the state enum (IDLE, LOCKED), the requester count constant NREQ=3, and the next-pointer function in shared package burst_arb_pkg.
REQ-030 SHALL use one sub-module, rr_pick3, which takes valid[2:0] and ptr and returns a 2-bit index plus an any-valid flag.

Verification
REQ-031 SHALL test: reset, then in_valid=3'b111 with out_ready=1 and all in_last=1 for 3 cycles -> out_sel 001, 010, 100; ptr returns to 0.
REQ-032 SHALL test: requester 1 sends a 4-beat burst while requester 0 is valid throughout -> out_sel=010 for all 4 fires, then 100 if valid else 001.
REQ-033 SHALL test: out_ready=0 for 5 cycles with in_valid=3'b001 -> out_sel held at 001; out_stall_cnt=5 with the macro and 0 without it.
REQ-034 SHALL test: LOCKED on requester 2 while in_valid[2] drops for 2 cycles and requester 0 is valid -> out_valid=0 and out_sel=000 for those cycles, no grant to requester 0.
REQ-035 SHALL test: reset asserted after beat 2 of a 4-beat burst -> next cycle IDLE, ptr=0, requester 0 wins if valid.
REQ-036 SHALL test, with STALL_W=4: 20 stall cycles -> out_stall_cnt saturates at 15; assertion that in_ready and out_sel are never multi-hot holds across all scenarios.

Source files
------------

// File: rtl/burst_arb_pkg.sv
// Shared definitions for the 3-requester burst round-robin arbiter:
// FSM state enum, requester count and pointer helpers.
package burst_arb_pkg;

    localparam int NREQ = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Round-robin successor of a requester index, wrapping 2 -> 0.
    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            2'd2:    nxt = 2'd0;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // Bit of a 3-bit request vector selected by a 2-bit index; index 3 reads as 0.
    function automatic logic req_bit(input logic [2:0] vec, input logic [1:0] idx);
        logic b;
        case (idx)
            2'd0:    b = vec[0];
            2'd1:    b = vec[1];
            2'd2:    b = vec[2];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/burst_rr_arbiter3_chk.sv
// Property checker for burst_rr_arbiter3: grant and ready vectors are never
// multi-hot, and out_sel is empty whenever out_valid is low.
module burst_rr_arbiter3_chk (
    input logic       clock,
    input logic [2:0] in_ready,
    input logic [2:0] out_sel,
    input logic       out_valid
);

    a_ready_onehot0: assert property (@(posedge clock) $onehot0(in_ready));
    a_sel_onehot0:   assert property (@(posedge clock) $onehot0(out_sel));
    a_sel_qualified: assert property (@(posedge clock) !out_valid |-> (out_sel == 3'b000));

endmodule

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: first valid requester scanning upward
// from ptr, modulo 3.
module rr_pick3
    import burst_arb_pkg::*;
(
    input  logic [2:0] valid,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand1_s;
    logic [1:0] cand2_s;

    // Scan ptr, ptr+1, ptr+2; with nothing valid the index parks on ptr.
    always_comb begin
        cand1_s = next_ptr(ptr);
        cand2_s = next_ptr(cand1_s);
        any     = |valid;
        if (req_bit(valid, ptr)) begin
            idx = ptr;
        end else if (req_bit(valid, cand1_s)) begin
            idx = cand1_s;
        end else if (req_bit(valid, cand2_s)) begin
            idx = cand2_s;
        end else begin
            idx = ptr;
        end
    end

endmodule

// File: rtl/burst_rr_arbiter3.sv
// Three-requester round-robin arbiter that locks onto a requester for a whole
// burst. Optional saturating stall counter enabled by macro ARB_STALL_CNT_EN.
module burst_rr_arbiter3
    import burst_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int STALL_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            in_valid,
    output logic [2:0]            in_ready,
    input  logic [3*DATA_W-1:0]   in_data,
    input  logic [2:0]            in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic [2:0]            out_sel,
    output logic [STALL_W-1:0]    out_stall_cnt
);

    arb_state_e state_r;
    logic [1:0] ptr_r;
    logic [1:0] lock_idx_r;
    logic       hold_r;
    logic [1:0] hold_idx_r;

    logic [1:0] pick_idx_s;
    logic       pick_any_s;
    logic [1:0] grant_s;
    logic       valid_s;
    logic       fire_s;
    logic       stall_s;

    rr_pick3 u_pick (
        .valid (in_valid),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // Grant source: burst owner, else the requester stalled last cycle, else the picker.
    always_comb begin
        if (state_r == LOCKED) begin
            grant_s = lock_idx_r;
            valid_s = req_bit(in_valid, lock_idx_r);
        end else if (hold_r) begin
            grant_s = hold_idx_r;
            valid_s = req_bit(in_valid, hold_idx_r);
        end else begin
            grant_s = pick_idx_s;
            valid_s = pick_any_s;
        end
    end

    assign fire_s  = valid_s & out_ready;
    assign stall_s = valid_s & ~out_ready;

    // Zero-latency output mux for the granted requester.
    always_comb begin
        out_valid = valid_s;
        out_sel   = onehot3(grant_s) & {3{valid_s}};
        in_ready  = {3{out_ready}} & out_sel;
        case (grant_s)
            2'd0:    out_data = in_data[0*DATA_W +: DATA_W];
            2'd1:    out_data = in_data[1*DATA_W +: DATA_W];
            2'd2:    out_data = in_data[2*DATA_W +: DATA_W];
            default: out_data = {DATA_W{1'b0}};
        endcase
        out_last = req_bit(in_last, grant_s);
    end

    // Burst FSM; hold_r pins an IDLE grant across back-pressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            ptr_r      <= 2'd0;
            lock_idx_r <= 2'd0;
            hold_r     <= 1'b0;
            hold_idx_r <= 2'd0;
        end else begin
            hold_r     <= stall_s;
            hold_idx_r <= grant_s;
            if (fire_s) begin
                if (out_last) begin
                    state_r <= IDLE;
                    ptr_r   <= next_ptr(grant_s);
                end else if (state_r == IDLE) begin
                    state_r    <= LOCKED;
                    lock_idx_r <= grant_s;
                end
            end
        end
    end

`ifdef ARB_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_r;

    // Saturating count of back-pressured cycles, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_r <= {STALL_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {STALL_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_stall_cnt = stall_cnt_r;
`else
    assign out_stall_cnt = {STALL_W{1'b0}};
`endif

endmodule
